// File: rtl/cic_comb_mc.sv
// cic_comb_mc: time-multiplexed, multi-channel CIC comb cascade.
// One sample at a time is pushed through STAGES comb stages (y = x - x[n-M])
// using a shared history RAM that is swept to zero after every reset.
//
// Input handshake: a sample transfers on a rising clk edge where
// in_valid && in_ready; in_ready is high only while idle. The output side has
// no backpressure: out_valid is a one-cycle pulse the consumer must take.
module cic_comb_mc #(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 8,
    parameter int STAGES     = 4,
    parameter int DIFF_DELAY = 1,
    localparam int CH_W      = $clog2(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_channel,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_channel,
    output logic signed [WIDTH-1:0] data_out,
    output logic [2:0]              dbg_state
);

    // One RAM word per (channel, stage) holds all M taps: tap0 in the low
    // WIDTH bits, tap1 (M=2) above it. The clear sweep still takes
    // CHANNELS*STAGES*M cycles; with M=2 each word is simply written twice.
    localparam int WORDS = CHANNELS * STAGES;
    localparam int CLR_N = WORDS * DIFF_DELAY;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = (CLR_N > 1) ? $clog2(CLR_N) : 1;
    localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int HW    = WIDTH * DIFF_DELAY;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_READ  = 3'd2,
        S_CALC  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             clr_q, clr_d;
    logic [SW-1:0]             s_q, s_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic signed [WIDTH-1:0]   x_q, x_d;
    logic                      out_valid_q, out_valid_d;
    logic [CH_W-1:0]           out_ch_q, out_ch_d;
    logic signed [WIDTH-1:0]   data_out_q, data_out_d;

    logic [HW-1:0]             mem [WORDS];
    logic [HW-1:0]             hist_q;
    logic [HW-1:0]             shift_word;
    logic signed [WIDTH-1:0]   h_old;
    logic [AW-1:0]             cur_addr;
    logic                      mem_we;
    logic [AW-1:0]             mem_waddr;
    logic [HW-1:0]             mem_wdata;

    assign cur_addr    = AW'(int'(ch_q) * STAGES + int'(s_q));
    assign h_old       = hist_q[HW-1 -: WIDTH];
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_channel = out_ch_q;
    assign data_out    = data_out_q;
    assign dbg_state   = state_q;

    // New history word: current stage input becomes tap0, old tap0 ages to tap1.
    generate
        if (DIFF_DELAY == 2) begin : g_m2
            assign shift_word = {hist_q[WIDTH-1:0], x_q};
        end else begin : g_m1
            assign shift_word = x_q;
        end
    endgenerate

    // Next-state, datapath and RAM write control for the clear/comb sequencer.
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        s_d         = s_q;
        ch_d        = ch_q;
        x_d         = x_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        data_out_d  = data_out_q;
        mem_we      = 1'b0;
        mem_waddr   = cur_addr;
        mem_wdata   = '0;
        unique case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(clr_q >> (DIFF_DELAY - 1));
                if (clr_q == CW'(CLR_N - 1)) begin
                    clr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    clr_d = clr_q + CW'(1);
                end
            end
            S_IDLE: begin
                // Samples for channels beyond CHANNELS are accepted and dropped.
                if (in_valid && (int'(in_channel) < CHANNELS)) begin
                    x_d     = data_in;
                    ch_d    = in_channel;
                    s_d     = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                mem_we    = 1'b1;
                mem_wdata = shift_word;
                x_d       = x_q - h_old;
                if (s_q == SW'(STAGES - 1)) begin
                    state_d = S_OUT;
                end else begin
                    s_d     = s_q + SW'(1);
                    state_d = S_READ;
                end
            end
            S_OUT: begin
                out_valid_d = 1'b1;
                out_ch_d    = ch_q;
                data_out_d  = x_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Control and output registers; reset aborts any sample and restarts the sweep.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_CLEAR;
            clr_q       <= '0;
            s_q         <= '0;
            ch_q        <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            s_q         <= s_d;
            ch_q        <= ch_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            data_out_q  <= data_out_d;
        end
    end

    // History RAM: one write port, one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (state_q == S_READ) begin
            hist_q <= mem[cur_addr];
        end
    end

endmodule

// File: tb/tb_cic_comb_mc.sv
// Bench for cic_comb_mc: four parameterisations share one stimulus bus,
// a selector routes in_valid to one instance at a time, and a scoreboard
// checks data, channel and latency of every output pulse.
module tb_cic_comb_mc;

  localparam int ST_A = 4;
  localparam int ST_B = 1;
  localparam int ST_C = 3;
  localparam int ST_D = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rstn;
  logic        in_valid;
  int          sel;
  logic [2:0]  in_ch;
  logic [31:0] din;
  logic [3:0]  vin, ready, ov;
  logic [2:0]  och_a;
  logic [0:0]  och_b;
  logic [1:0]  och_c;
  logic [0:0]  och_d;
  logic [31:0] dout_a;
  logic [7:0]  dout_b;
  logic [15:0] dout_c, dout_d;
  logic [2:0]  dbg_a, dbg_b, dbg_c, dbg_d;

  assign vin = in_valid ? (4'b0001 << sel) : 4'b0000;

  cic_comb_mc #(.WIDTH(32), .CHANNELS(8), .STAGES(ST_A), .DIFF_DELAY(1)) u_a (
    .clk(clk), .resetn(rstn[0]), .in_valid(vin[0]), .in_ready(ready[0]),
    .in_channel(in_ch), .data_in(din), .out_valid(ov[0]),
    .out_channel(och_a), .data_out(dout_a), .dbg_state(dbg_a));

  cic_comb_mc #(.WIDTH(8), .CHANNELS(2), .STAGES(ST_B), .DIFF_DELAY(1)) u_b (
    .clk(clk), .resetn(rstn[1]), .in_valid(vin[1]), .in_ready(ready[1]),
    .in_channel(in_ch[0:0]), .data_in(din[7:0]), .out_valid(ov[1]),
    .out_channel(och_b), .data_out(dout_b), .dbg_state(dbg_b));

  cic_comb_mc #(.WIDTH(16), .CHANNELS(3), .STAGES(ST_C), .DIFF_DELAY(1)) u_c (
    .clk(clk), .resetn(rstn[2]), .in_valid(vin[2]), .in_ready(ready[2]),
    .in_channel(in_ch[1:0]), .data_in(din[15:0]), .out_valid(ov[2]),
    .out_channel(och_c), .data_out(dout_c), .dbg_state(dbg_c));

  cic_comb_mc #(.WIDTH(16), .CHANNELS(2), .STAGES(ST_D), .DIFF_DELAY(2)) u_d (
    .clk(clk), .resetn(rstn[3]), .in_valid(vin[3]), .in_ready(ready[3]),
    .in_channel(in_ch[0:0]), .data_in(din[15:0]), .out_valid(ov[3]),
    .out_channel(och_d), .data_out(dout_d), .dbg_state(dbg_d));

  // Output of the selected instance, sign-extended to 32 bits.
  logic        ov_s;
  logic [31:0] dout_s;
  logic [2:0]  och_s;
  always_comb begin
    ov_s   = 1'b0;
    dout_s = '0;
    och_s  = '0;
    case (sel)
      0: begin ov_s = ov[0]; dout_s = dout_a; och_s = och_a; end
      1: begin ov_s = ov[1]; dout_s = {{24{dout_b[7]}}, dout_b}; och_s = {2'b00, och_b}; end
      2: begin ov_s = ov[2]; dout_s = {{16{dout_c[15]}}, dout_c}; och_s = {1'b0, och_c}; end
      3: begin ov_s = ov[3]; dout_s = {{16{dout_d[15]}}, dout_d}; och_s = {2'b00, och_d}; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1;
  logic [34:0] exp_q[$];
  int          acc_q[$];
  int          hist_a [8][4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int st_of(int k);
    case (k)
      0: return ST_A;
      1: return ST_B;
      2: return ST_C;
      default: return ST_D;
    endcase
  endfunction

  // Reference comb cascade for instance A (M=1, four stages, 32-bit wrap).
  function automatic int model_a(int ch, int x);
    int y = x;
    for (int s = 0; s < ST_A; s++) begin
      int t = y - hist_a[ch][s];
      hist_a[ch][s] = y;
      y = t;
    end
    return y;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Scoreboard: every out_valid pulse of the selected instance is matched
  // against the oldest pending expectation; other instances must stay quiet.
  always @(negedge clk) begin
    logic [34:0] e;
    int          a;
    if (ov_s) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output inst%0d: got data %0d, expected no output",
                 sel, $signed(dout_s));
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check($sformatf("data inst%0d", sel), dout_s, e[31:0]);
        check($sformatf("channel inst%0d", sel), {29'd0, och_s}, {29'd0, e[34:32]});
        check($sformatf("latency inst%0d", sel), cyc - a, 2 * st_of(sel) + 1);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (ov[k] && k != sel) begin
        checks++;
        errors++;
        $display("FAIL stray_output inst%0d: got out_valid 1, expected 0", k);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outputs missing, expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // Drive one sample into instance k; optionally expect an output for it
  // and check the spacing to the previous accepted sample.
  task automatic send(int k, int ch, int data, int exp, bit push, bit chk_gap);
    int n = 0;
    if (k != sel) begin
      drain();
      sel = k;
      last_acc = -1;
    end
    while (!ready[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready[k]) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout inst%0d: in_ready 0 after %0d cycles, expected 1", k, n);
      return;
    end
    in_valid = 1'b1;
    in_ch    = ch[2:0];
    din      = data;
    if (push) begin
      exp_q.push_back({ch[2:0], exp});
      acc_q.push_back(cyc + 1);
    end
    if (chk_gap && last_acc >= 0)
      check($sformatf("throughput inst%0d", k), cyc + 1 - last_acc, 2 * st_of(k) + 2);
    last_acc = push ? cyc + 1 : -1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic reset_inst(int k);
    rstn[k] = 1'b0;
    repeat (2) @(negedge clk);
    rstn[k] = 1'b1;
    last_acc = -1;
  endtask

  typedef struct {
    bit rst;
    int inst;
    int ch;
    int data;
    int exp;
  } vec_t;

  vec_t vt[19];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int ch;
    int d;
    int e;
    int last_e;
    int last_ch;

    // Impulse through three stages on C, then step on C channel 1.
    vt[0]  = '{0, 2, 0, 1, 1};
    vt[1]  = '{0, 2, 0, 0, -3};
    vt[2]  = '{0, 2, 0, 0, 3};
    vt[3]  = '{0, 2, 0, 0, -1};
    vt[4]  = '{0, 2, 0, 0, 0};
    vt[5]  = '{0, 2, 1, 5, 5};
    vt[6]  = '{0, 2, 1, 5, -10};
    // Channel isolation on B.
    vt[7]  = '{0, 1, 0, 10, 10};
    vt[8]  = '{0, 1, 1, 100, 100};
    vt[9]  = '{0, 1, 0, 20, 10};
    vt[10] = '{0, 1, 1, 100, 0};
    vt[11] = '{0, 1, 0, 30, 10};
    vt[12] = '{0, 1, 1, 100, 0};
    // 8-bit wrap-around on B after a fresh reset.
    vt[13] = '{1, 1, 1, 127, 127};
    vt[14] = '{0, 1, 1, -128, 1};
    // Differential delay 2 on D.
    vt[15] = '{0, 3, 1, 1, 1};
    vt[16] = '{0, 3, 1, 2, 2};
    vt[17] = '{0, 3, 1, 4, 3};
    vt[18] = '{0, 3, 1, 8, 6};

    // Clock/reset.
    rstn     = 4'b0000;
    in_valid = 1'b0;
    sel      = 0;
    in_ch    = '0;
    din      = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", {31'd0, ready[0]}, 0);
    check("reset out_valid", {31'd0, ov[0]}, 0);
    check("reset data_out", dout_a, 0);
    check("reset out_channel", {29'd0, och_a}, 0);

    // Clear sweep: count cycles with in_ready low from reset release.
    rstn = 4'b1111;
    n = 0;
    while (!ready[0] && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("clear_sweep_cycles", n, 32);

    send(0, 3, 7, 7, 1'b1, 1'b0);
    void'(model_a(3, 7));

    // Random traffic on A against the reference model.
    last_e  = 7;
    last_ch = 3;
    for (int i = 0; i < 16; i++) begin
      ch = $urandom_range(0, 7);
      d  = $urandom;
      e  = model_a(ch, d);
      send(0, ch, d, e, 1'b1, 1'b1);
      last_e  = e;
      last_ch = ch;
    end
    drain();
    repeat (3) @(negedge clk);
    check("hold data_out", dout_a, last_e);
    check("hold out_channel", {29'd0, och_a}, last_ch);

    // Reset while stage 2 of a sample is being computed.
    send(0, 3, 32'h1234, 0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("midop state is calc", {29'd0, dbg_a}, 3);
    #2;
    rstn[0] = 1'b0;
    #1;
    check("midop reset in_ready", {31'd0, ready[0]}, 0);
    check("midop reset out_valid", {31'd0, ov[0]}, 0);
    check("midop reset data_out", dout_a, 0);
    check("midop reset out_channel", {29'd0, och_a}, 0);
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1;
    last_acc = -1;
    repeat (12) @(negedge clk);
    send(0, 3, 5, 5, 1'b1, 1'b0);
    drain();

    // Table-driven vectors.
    for (int i = 0; i < 19; i++) begin
      if (vt[i].rst) begin
        drain();
        sel = vt[i].inst;
        reset_inst(vt[i].inst);
      end
      send(vt[i].inst, vt[i].ch, vt[i].data, vt[i].exp, 1'b1, 1'b1);
    end
    drain();

    // Out-of-range channel on C is dropped and leaves state untouched.
    send(2, 3, 99, 0, 1'b0, 1'b0);
    check("drop stays idle", {29'd0, dbg_c}, 1);
    check("drop in_ready", {31'd0, ready[2]}, 1);
    send(2, 0, 4, 4, 1'b1, 1'b0);
    send(2, 1, 5, 5, 1'b1, 1'b1);
    drain();
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
